majority_bist: RTL and testbench
================================

Name: majority_bist

Overview:
- Self-contained built-in self-test controller for an N-input majority voter.
- On `start`, drives every input pattern 0 .. 2^N-1 into the voter in order and samples the voter output after a settle interval.
- Compares each sample against the majority value it computes internally, then reports pass/fail, a failure count and the first failing pattern.
- Sits beside the majority voter as its on-chip stimulus source and response checker, in place of a simulation-only bench.

Parameters:
- N, 3, number of voter inputs; must be odd and ≥3 (elaboration-time check fails otherwise).
- SETTLE_CYCLES, 2, clock cycles each pattern is held before the voter output is sampled; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a test run; sampled on a rising edge.
- dut_f  input  1  output of the voter under test.
- pat  output  N  pattern driven to the voter; pat[N-1] is input A (MSB), pat[0] is the last input.
- busy  output  1  high while a run is in progress.
- done  output  1  high from end of run until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff fail_count==0.
- fail_count  output  N+1  number of mismatching patterns in the last run.
- first_fail_valid  output  1  at least one mismatch has been recorded.
- first_fail_pat  output  N  pattern of the first mismatch.

Behaviour:
- Reset (asynchronous, any state including mid-run):
  - state=IDLE, pat=0, busy=0, done=0, pass=0, fail_count=0, first_fail_valid=0, first_fail_pat=0, settle counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → RUN; pat=0, settle_cnt=0, fail_count=0, first_fail_valid=0, first_fail_pat=0, done=0, pass=0, busy=1.
- RUN:
  - Each pattern is held for exactly SETTLE_CYCLES cycles.
  - At each edge with settle_cnt<SETTLE_CYCLES-1: increment settle_cnt.
  - At the edge with settle_cnt==SETTLE_CYCLES-1:
    - Compare dut_f with expected = (popcount(pat) > N/2).
    - On mismatch, fail_count+=1. If first_fail_valid==0, capture first_fail_pat=pat and set first_fail_valid=1.
    - If pat==all-ones: → DONE, busy=0, done=1, and pass = (updated fail_count==0).
    - Otherwise pat+=1 and settle_cnt=0.
- DONE:
  - Results hold; pat holds all-ones.
  - start=1 → behaves exactly as start from IDLE (new run, results cleared on the same edge).
- start while busy=1 is ignored and has no effect on the run.
- Latency: done rises on the edge 2^N × SETTLE_CYCLES edges after the accepting edge. For N=3, S=2 that is 16 cycles.
- fail_count cannot overflow: the maximum is 2^N, which fits in N+1 bits.
- popcount is computed combinationally over N bits. The comparison uses the registered pat, so the voter sees a stable input for the whole settle window.
- All outputs are registered. There are no combinational paths from start or dut_f to any output.

Decomposition:
- Shared package `majority_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - Default N and SETTLE_CYCLES constants.
  - `majority_ref(vec)` function returning popcount>N/2. The voter and this block both use it so the golden model has a single source.
- Natural sub-module: `majority_ref_model`, a combinational N-input reference voter producing the expected bit. It is instantiated once; everything else stays in `majority_bist`.

Test Plan:
- Correct 3-input majority voter on dut_f, N=3, S=2, start pulse → busy high for 16 cycles; pat steps 000..111 every 2 cycles; done=1, pass=1, fail_count=0, first_fail_valid=0.
- dut_f tied 0 → done at cycle 16; pass=0, fail_count=4, first_fail_pat=3'b011, first_fail_valid=1.
- dut_f = inverted correct voter → fail_count=8, first_fail_pat=3'b000.
- dut_f = A&B (pat[2]&pat[1]) → fail_count=2, first_fail_pat=3'b011 (101 also fails; 110 and 111 pass).
- rst asserted at cycle 7 of a run, start re-pulsed after release → all outputs zero immediately on reset; new run completes 16 cycles later with correct results. start pulsed at cycle 5 of a run → ignored, done still at cycle 16.
- Restart from DONE with the failing dut_f from the previous run, then a correct voter, S=1 → results clear on the accepting edge; done after 8 cycles; pass=1, fail_count=0.

Source files
------------

// File: rtl/majority_pkg.sv
// Shared definitions for the majority-voter BIST: FSM states, default sizing
// and the golden majority function used by both the voter and its checker.
package majority_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N             = 3;
  localparam int DEFAULT_SETTLE_CYCLES = 2;
  localparam int MAX_N                 = 32;

  // Only the low n bits of vec take part in the vote; the rest are ignored.
  function automatic logic majority_ref(input logic [MAX_N-1:0] vec,
                                        input int unsigned      n);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        ones = ones + {31'b0, vec[i]};
      end
    end
    return (ones > (n / 2));
  endfunction

endpackage

// File: rtl/majority_bist_if.sv
// Stimulus/response bundle between the BIST controller and whoever starts it
// and reads back the results; the voter output also travels on it.
interface majority_bist_if
  import majority_pkg::*;
#(
  parameter int N = DEFAULT_N
);
  logic         start;
  logic         dut_f;
  logic [N-1:0] pat;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   fail_count;
  logic         first_fail_valid;
  logic [N-1:0] first_fail_pat;

  modport master (
    output start, dut_f,
    input  pat, busy, done, pass, fail_count, first_fail_valid, first_fail_pat
  );

  modport slave (
    input  start, dut_f,
    output pat, busy, done, pass, fail_count, first_fail_valid, first_fail_pat
  );
endinterface

// File: rtl/majority_bist_ref_model.sv
// Combinational N-input reference voter producing the expected output bit
// for the pattern currently applied to the voter under test.
module majority_ref_model
  import majority_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] i_vec,
  output logic         o_maj
);
  logic [MAX_N-1:0] w_ext;

  if (N > MAX_N) begin : g_too_wide
    $error("majority_ref_model: N exceeds MAX_N");
  end

  assign w_ext = MAX_N'(i_vec);
  assign o_maj = majority_ref(w_ext, N);
endmodule

// File: rtl/majority_bist.sv
// BIST controller: sweeps every N-bit pattern through the voter, holds each
// for SETTLE_CYCLES, checks the voter against the reference and logs results.
module majority_bist
  import majority_pkg::*;
#(
  parameter int N             = DEFAULT_N,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  majority_bist_if.slave   io_bus
);
  localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N-1:0]     PAT_LAST    = '1;

  if (N < 3 || (N % 2) == 0) begin : g_bad_n
    $error("majority_bist: N must be odd and at least 3");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("majority_bist: SETTLE_CYCLES must be at least 1");
  end

  state_t           r_state;
  logic [N-1:0]     r_pat;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [N:0]       r_fail_count;
  logic             r_ffv;
  logic [N-1:0]     r_ffp;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  state_t           w_state_next;
  logic [N-1:0]     w_pat_next;
  logic [CNT_W-1:0] w_settle_cnt_next;
  logic [N:0]       w_fail_count_next;
  logic             w_ffv_next;
  logic [N-1:0]     w_ffp_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic             w_pass_next;

  logic             w_expected;
  logic             w_mismatch;
  logic [N:0]       w_fail_upd;

  // The reference sees the registered pattern, the same stable value the voter sees.
  majority_ref_model #(.N(N)) u_ref (
    .i_vec (r_pat),
    .o_maj (w_expected)
  );

  assign w_mismatch = (io_bus.dut_f != w_expected);
  assign w_fail_upd = r_fail_count + (N+1)'(w_mismatch);

  always_comb begin
    w_state_next      = r_state;
    w_pat_next        = r_pat;
    w_settle_cnt_next = r_settle_cnt;
    w_fail_count_next = r_fail_count;
    w_ffv_next        = r_ffv;
    w_ffp_next        = r_ffp;
    w_busy_next       = r_busy;
    w_done_next       = r_done;
    w_pass_next       = r_pass;

    unique case (r_state)
      IDLE, DONE: begin
        if (io_bus.start) begin
          w_state_next      = RUN;
          w_pat_next        = '0;
          w_settle_cnt_next = '0;
          w_fail_count_next = '0;
          w_ffv_next        = 1'b0;
          w_ffp_next        = '0;
          w_busy_next       = 1'b1;
          w_done_next       = 1'b0;
          w_pass_next       = 1'b0;
        end
      end

      RUN: begin
        if (r_settle_cnt != SETTLE_LAST) begin
          w_settle_cnt_next = r_settle_cnt + 1'b1;
        end else begin
          w_fail_count_next = w_fail_upd;
          if (w_mismatch && !r_ffv) begin
            w_ffv_next = 1'b1;
            w_ffp_next = r_pat;
          end
          if (r_pat == PAT_LAST) begin
            w_state_next = DONE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_pass_next  = (w_fail_upd == '0);
          end else begin
            w_pat_next        = r_pat + 1'b1;
            w_settle_cnt_next = '0;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pat        <= '0;
      r_settle_cnt <= '0;
      r_fail_count <= '0;
      r_ffv        <= 1'b0;
      r_ffp        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pat        <= w_pat_next;
      r_settle_cnt <= w_settle_cnt_next;
      r_fail_count <= w_fail_count_next;
      r_ffv        <= w_ffv_next;
      r_ffp        <= w_ffp_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_pass       <= w_pass_next;
    end
  end

  assign io_bus.pat              = r_pat;
  assign io_bus.busy             = r_busy;
  assign io_bus.done             = r_done;
  assign io_bus.pass             = r_pass;
  assign io_bus.fail_count       = r_fail_count;
  assign io_bus.first_fail_valid = r_ffv;
  assign io_bus.first_fail_pat   = r_ffp;
endmodule

// File: tb/tb_majority_bist.sv
// Bench for majority_bist: fixed voter faults from a table, random faulty
// voters against a popcount model, plus reset/ignored-start/restart sequences.
module tb_majority_bist;
  import majority_pkg::*;

  logic clk;
  logic rst;
  int   mode;
  logic [7:0] lut;
  int   tests;
  int   failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  majority_bist_if #(.N(3)) ifa ();
  majority_bist_if #(.N(3)) ifb ();

  majority_bist #(.N(3), .SETTLE_CYCLES(2)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .io_bus (ifa)
  );

  majority_bist #(.N(3), .SETTLE_CYCLES(1)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .io_bus (ifb)
  );

  // Voter models: 0 correct, 1 stuck-at-0, 2 inverted, 3 A&B, other: lookup table
  function automatic logic voter(input int m, input logic [2:0] p, input logic [7:0] l);
    case (m)
      0:       return ($countones(p) >= 2);
      1:       return 1'b0;
      2:       return !($countones(p) >= 2);
      3:       return p[2] & p[1];
      default: return l[p];
    endcase
  endfunction

  assign ifa.dut_f = voter(mode, ifa.pat, lut);
  assign ifb.dut_f = voter(mode, ifb.pat, lut);

  typedef struct {
    int pat;
    int busy;
    int done;
    int pass;
    int fc;
    int ffv;
    int ffp;
  } outs_t;

  typedef struct {
    int mode;
    int fc;
    int pass;
    int ffv;
    int ffp;
  } vec_t;

  vec_t tbl [4];

  function automatic outs_t sample(input int which);
    outs_t o;
    if (which == 0) begin
      o.pat = int'(ifa.pat);   o.busy = int'(ifa.busy); o.done = int'(ifa.done);
      o.pass = int'(ifa.pass); o.fc = int'(ifa.fail_count);
      o.ffv = int'(ifa.first_fail_valid); o.ffp = int'(ifa.first_fail_pat);
    end else begin
      o.pat = int'(ifb.pat);   o.busy = int'(ifb.busy); o.done = int'(ifb.done);
      o.pass = int'(ifb.pass); o.fc = int'(ifb.fail_count);
      o.ffv = int'(ifb.first_fail_valid); o.ffp = int'(ifb.first_fail_pat);
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) ifa.start = v;
    else            ifb.start = v;
  endtask

  // Model: sweep every pattern, compare the voter against popcount majority.
  task automatic model(input int m, input logic [7:0] l, output vec_t e);
    e.mode = m; e.fc = 0; e.ffv = 0; e.ffp = 0;
    for (int p = 0; p < 8; p++) begin
      logic [2:0] pv;
      pv = 3'(p);
      if (voter(m, pv, l) != ($countones(pv) > 1)) begin
        if (e.ffv == 0) begin
          e.ffv = 1;
          e.ffp = p;
        end
        e.fc++;
      end
    end
    e.pass = (e.fc == 0) ? 1 : 0;
  endtask

  task automatic check_zero(input int which, input string tag);
    outs_t o;
    o = sample(which);
    chk({tag, "_pat"},  o.pat,  0);
    chk({tag, "_busy"}, o.busy, 0);
    chk({tag, "_done"}, o.done, 0);
    chk({tag, "_pass"}, o.pass, 0);
    chk({tag, "_fc"},   o.fc,   0);
    chk({tag, "_ffv"},  o.ffv,  0);
    chk({tag, "_ffp"},  o.ffp,  0);
  endtask

  task automatic check_results(input int which, input vec_t e, input string tag);
    outs_t o;
    o = sample(which);
    chk({tag, "_fc"},   o.fc,   e.fc);
    chk({tag, "_pass"}, o.pass, e.pass);
    chk({tag, "_ffv"},  o.ffv,  e.ffv);
    if (e.ffv != 0) chk({tag, "_ffp"}, o.ffp, e.ffp);
    $display("[TB] run dut=%0d mode=%0d fail_count=%0d pass=%0d first=%0d/%0d",
             which, e.mode, o.fc, o.pass, o.ffv, o.ffp);
  endtask

  // One run: pulse start, follow the sweep cycle by cycle, optionally inject
  // a start pulse or an asynchronous reset at a given cycle after acceptance.
  task automatic run(input int which, input int pulse_at, input int rst_at, output bit aborted);
    int    s;
    int    total;
    outs_t o;
    s = (which == 0) ? 2 : 1;
    total = 8 * s;
    aborted = 1'b0;
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    set_start(which, 1'b0);
    o = sample(which);
    chk("accept_busy", o.busy, 1);
    chk("accept_done", o.done, 0);
    chk("accept_pass", o.pass, 0);
    chk("accept_fc",   o.fc,   0);
    chk("accept_ffv",  o.ffv,  0);
    chk("accept_pat",  o.pat,  0);
    for (int k = 1; k <= total; k++) begin
      if (k == pulse_at) set_start(which, 1'b1);
      @(posedge clk);
      #1;
      set_start(which, 1'b0);
      if (k == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        check_zero(which, "midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      o = sample(which);
      if (k < total) begin
        chk("run_busy", o.busy, 1);
        chk("run_done", o.done, 0);
        chk("run_pat",  o.pat,  k / s);
      end else begin
        chk("end_busy", o.busy, 0);
        chk("end_done", o.done, 1);
        chk("end_pat",  o.pat,  7);
      end
    end
  endtask

  initial begin
    vec_t  e;
    bit    ab;
    outs_t o;
    tests  = 0;
    failed = 0;
    mode   = 0;
    lut    = '0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst    = 1'b1;

    tbl[0] = '{mode: 0, fc: 0, pass: 1, ffv: 0, ffp: 0};
    tbl[1] = '{mode: 1, fc: 4, pass: 0, ffv: 1, ffp: 3};
    tbl[2] = '{mode: 2, fc: 8, pass: 0, ffv: 1, ffp: 0};
    tbl[3] = '{mode: 3, fc: 2, pass: 0, ffv: 1, ffp: 3};

    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
    @(negedge clk);
    rst = 1'b0;

    // Fixed voter faults with hand-derived results
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run(0, 0, 0, ab);
      check_results(0, tbl[i], $sformatf("tbl%0d", i));
    end

    // Results and pattern hold in DONE
    repeat (3) @(posedge clk);
    #1;
    o = sample(0);
    chk("hold_done", o.done, 1);
    chk("hold_pat",  o.pat,  7);
    chk("hold_fc",   o.fc,   2);

    // Random faulty voters against the model, on both settle settings
    for (int r = 0; r < 8; r++) begin
      lut  = 8'($urandom);
      mode = 4;
      model(mode, lut, e);
      run(r % 2, 0, 0, ab);
      check_results(r % 2, e, $sformatf("rand%0d", r));
    end

    // Asynchronous reset mid-run, then a clean run
    mode = 0;
    run(0, 0, 7, ab);
    chk("rst_aborted", int'(ab), 1);
    run(0, 0, 0, ab);
    check_results(0, tbl[0], "after_rst");

    // Start while busy is ignored
    mode = 1;
    run(0, 5, 0, ab);
    check_results(0, tbl[1], "ignored_start");

    // Restart from DONE on the S=1 instance
    mode = 1;
    run(1, 0, 0, ab);
    check_results(1, tbl[1], "b_fail");
    mode = 0;
    run(1, 0, 0, ab);
    check_results(1, tbl[0], "b_restart");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
